mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_wdt.sv | 30 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and the side-select values held in the last-grant flag.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_t;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/mem_arb_wdt.sv
// Grant watchdog: counts stalled grant cycles and flags the cycle in which
// the count reaches TIMEOUT, so the arbiter can abort the grant.
module mem_arb_wdt #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + ONE;
        end
    end

    // Expire when this enabled cycle would bring the count up to TIMEOUT.
    assign o_expire = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between an instruction side
// and a data side, with a registered grant and a stall watchdog.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int A_WIDTH = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] i_a,
    input  logic [31:0]        i_dout,
    input  logic               i_strobe,
    input  logic [3:0]         i_wen,
    input  logic [1:0]         i_size,
    input  logic               i_rw,
    output logic [31:0]        i_din,
    output logic               i_ready,
    input  logic [A_WIDTH-1:0] d_a,
    input  logic [31:0]        d_dout,
    input  logic               d_strobe,
    input  logic [3:0]         d_wen,
    input  logic [1:0]         d_size,
    input  logic               d_rw,
    output logic [31:0]        d_din,
    output logic               d_ready,
    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    output logic               m_strobe,
    output logic [3:0]         m_wen,
    output logic [1:0]         m_size,
    output logic               m_rw,
    input  logic [31:0]        m_dout,
    input  logic               m_ready,
    output logic               err_timeout,
    output logic [1:0]         o_dbg_state
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_last;
    logic       w_last_next;
    logic       r_err;
    logic       w_abort;
    logic       w_gnt_strobe;
    logic       w_gnt_sel;
    logic       w_expire;
    logic       w_wdt_clear;
    logic       w_wdt_enable;

    assign w_wdt_clear  = (r_state == ST_IDLE);
    assign w_wdt_enable = (r_state != ST_IDLE) && !m_ready;

    mem_arb_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_wdt_clear),
        .i_enable (w_wdt_enable),
        .o_expire (w_expire)
    );

    assign w_gnt_sel    = (r_state == ST_GNT_D) ? SEL_D : SEL_I;
    assign w_gnt_strobe = (r_state == ST_GNT_D) ? d_strobe : i_strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= SEL_I;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_next;
            r_err   <= w_abort;
        end
    end

    // Completion wins over abandon, abandon wins over watchdog abort.
    always_comb begin
        w_next      = r_state;
        w_last_next = r_last;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_strobe && d_strobe) begin
                    w_next = (r_last == SEL_I) ? ST_GNT_D : ST_GNT_I;
                end else if (d_strobe) begin
                    w_next = ST_GNT_D;
                end else if (i_strobe) begin
                    w_next = ST_GNT_I;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (m_ready) begin
                    w_next      = ST_IDLE;
                    w_last_next = w_gnt_sel;
                end else if (!w_gnt_strobe) begin
                    w_next = ST_IDLE;
                end else if (w_expire) begin
                    w_next      = ST_IDLE;
                    w_last_next = w_gnt_sel;
                    w_abort     = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        m_a      = '0;
        m_din    = '0;
        m_strobe = 1'b0;
        m_wen    = '0;
        m_size   = '0;
        m_rw     = 1'b0;
        case (r_state)
            ST_GNT_I: begin
                m_a      = i_a;
                m_din    = i_dout;
                m_strobe = i_strobe;
                m_wen    = i_wen;
                m_size   = i_size;
                m_rw     = i_rw;
            end
            ST_GNT_D: begin
                m_a      = d_a;
                m_din    = d_dout;
                m_strobe = d_strobe;
                m_wen    = d_wen;
                m_size   = d_size;
                m_rw     = d_rw;
            end
            default: ;
        endcase
    end

    assign i_ready     = m_ready && (r_state == ST_GNT_I);
    assign d_ready     = m_ready && (r_state == ST_GNT_D);
    assign i_din       = m_dout;
    assign d_din       = m_dout;
    assign err_timeout = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, round-robin ties, no preemption,
// watchdog abort, abandon, reset mid-transfer and stray m_ready.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] i_a, d_a, m_a;
    logic [31:0]   i_dout, d_dout, m_din, m_dout, i_din, d_din;
    logic          i_strobe, d_strobe, m_strobe;
    logic [3:0]    i_wen, d_wen, m_wen;
    logic [1:0]    i_size, d_size, m_size;
    logic          i_rw, d_rw, m_rw;
    logic          i_ready, d_ready, m_ready, err_timeout;
    logic [1:0]    o_dbg_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.A_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_a(i_a), .i_dout(i_dout), .i_strobe(i_strobe), .i_wen(i_wen),
        .i_size(i_size), .i_rw(i_rw), .i_din(i_din), .i_ready(i_ready),
        .d_a(d_a), .d_dout(d_dout), .d_strobe(d_strobe), .d_wen(d_wen),
        .d_size(d_size), .d_rw(d_rw), .d_din(d_din), .d_ready(d_ready),
        .m_a(m_a), .m_din(m_din), .m_strobe(m_strobe), .m_wen(m_wen),
        .m_size(m_size), .m_rw(m_rw), .m_dout(m_dout), .m_ready(m_ready),
        .err_timeout(err_timeout), .o_dbg_state(o_dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_a = '0; i_dout = '0; i_strobe = 0; i_wen = '0; i_size = '0; i_rw = 0;
        d_a = '0; d_dout = '0; d_strobe = 0; d_wen = '0; d_size = '0; d_rw = 0;
        m_dout = '0; m_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        do_reset();
        mid();
        check("rst_state", 32'(o_dbg_state), 32'd0);
        check("rst_m_strobe", 32'(m_strobe), 32'd0);
        check("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_m_a", m_a, 32'd0);

        // Data side alone, memory answers in the third grant cycle.
        tick();
        d_strobe = 1; d_a = 32'h1000_0004; d_wen = 4'hf; d_size = 2'd2;
        mid();
        check("d_req_not_yet", 32'(m_strobe), 32'd0);
        tick();
        mid();
        check("d_gnt_state", 32'(o_dbg_state), 32'd2);
        check("d_gnt_strobe", 32'(m_strobe), 32'd1);
        check("d_gnt_m_a", m_a, 32'h1000_0004);
        check("d_gnt_m_wen_size", {26'd0, m_wen, m_size}, {26'd0, 4'hf, 2'd2});
        tick();
        mid();
        check("d_wait_ready", {30'd0, i_ready, d_ready}, 32'd0);
        tick();
        m_ready = 1; m_dout = 32'hA5A5_0001;
        mid();
        check("d_done_ready", {30'd0, i_ready, d_ready}, 32'd1);
        check("d_din", d_din, 32'hA5A5_0001);
        check("i_din", i_din, 32'hA5A5_0001);
        tick();
        m_ready = 0; d_strobe = 0;
        mid();
        check("d_back_idle", 32'(o_dbg_state), 32'd0);
        check("d_idle_ready", 32'(d_ready), 32'd0);

        // Tie after reset goes to data, then instruction, then data again.
        do_reset();
        i_strobe = 1; i_a = 32'h2000_0000; i_dout = 32'hDEAD_BEEF; i_rw = 1;
        d_strobe = 1; d_a = 32'h3000_0000;
        tick();
        m_ready = 1;
        mid();
        check("tie1_state", 32'(o_dbg_state), 32'd2);
        check("tie1_m_a", m_a, 32'h3000_0000);
        check("tie1_ready", {30'd0, i_ready, d_ready}, 32'd1);
        tick();
        m_ready = 0; d_strobe = 0;
        mid();
        check("tie1_bubble", 32'(o_dbg_state), 32'd0);
        check("tie1_bubble_strobe", 32'(m_strobe), 32'd0);
        tick();
        m_ready = 1;
        mid();
        check("tie1_i_state", 32'(o_dbg_state), 32'd1);
        check("tie1_i_m_a", m_a, 32'h2000_0000);
        check("tie1_i_m_din", m_din, 32'hDEAD_BEEF);
        check("tie1_i_m_rw", 32'(m_rw), 32'd1);
        check("tie1_i_ready", {30'd0, i_ready, d_ready}, 32'd2);
        tick();
        m_ready = 0;
        d_strobe = 1;
        mid();
        check("tie2_idle", 32'(o_dbg_state), 32'd0);
        tick();
        mid();
        check("tie2_state", 32'(o_dbg_state), 32'd2);
        m_ready = 1;
        tick();
        m_ready = 0; i_strobe = 0; d_strobe = 0; i_rw = 0;

        // No preemption: data raises its strobe during an instruction grant.
        i_strobe = 1; i_a = 32'h0000_0100;
        d_a = 32'h0000_0200;
        tick();
        mid();
        check("np_i_state", 32'(o_dbg_state), 32'd1);
        tick();
        d_strobe = 1;
        mid();
        check("np_hold_m_a", m_a, 32'h0000_0100);
        check("np_hold_state", 32'(o_dbg_state), 32'd1);
        tick();
        m_ready = 1;
        mid();
        check("np_done_m_a", m_a, 32'h0000_0100);
        check("np_done_ready", {30'd0, i_ready, d_ready}, 32'd2);
        tick();
        m_ready = 0; i_strobe = 0;
        mid();
        check("np_bubble", 32'(o_dbg_state), 32'd0);
        tick();
        m_ready = 1;
        mid();
        check("np_d_state", 32'(o_dbg_state), 32'd2);
        check("np_d_m_a", m_a, 32'h0000_0200);
        check("np_d_ready", {30'd0, i_ready, d_ready}, 32'd1);
        tick();
        m_ready = 0; d_strobe = 0;

        // Watchdog: eight stalled grant cycles then abort.
        d_strobe = 1; d_a = 32'h0000_0300;
        for (int k = 1; k <= TO; k++) begin
            tick();
            mid();
            check($sformatf("wdt_hold_%0d", k),
                  {28'd0, o_dbg_state, d_ready, err_timeout}, {28'd0, 2'd2, 1'b0, 1'b0});
        end
        tick();
        d_strobe = 0;
        mid();
        check("wdt_abort_state", 32'(o_dbg_state), 32'd0);
        check("wdt_abort_err", 32'(err_timeout), 32'd1);
        check("wdt_abort_ready", {30'd0, i_ready, d_ready}, 32'd0);
        tick();
        i_strobe = 1; d_strobe = 1;
        mid();
        check("wdt_err_pulse", 32'(err_timeout), 32'd0);
        tick();
        mid();
        check("wdt_tie_to_i", 32'(o_dbg_state), 32'd1);
        m_ready = 1;
        tick();
        m_ready = 0; i_strobe = 0; d_strobe = 0;

        // Abandon: data drops its strobe mid-grant; last grant stays I.
        d_strobe = 1;
        tick();
        d_strobe = 0;
        mid();
        check("ab_strobe_follows", 32'(m_strobe), 32'd0);
        tick();
        i_strobe = 1; d_strobe = 1;
        mid();
        check("ab_idle", {30'd0, o_dbg_state}, 32'd0);
        check("ab_no_err", 32'(err_timeout), 32'd0);
        tick();
        mid();
        check("ab_tie_to_d", 32'(o_dbg_state), 32'd2);
        m_ready = 1;
        tick();
        m_ready = 0; i_strobe = 0; d_strobe = 0;

        // Reset during a data write; the write is dropped and last grant is I.
        d_strobe = 1; d_rw = 1; d_dout = 32'h1234_5678;
        tick();
        mid();
        check("rw_gnt_write", {30'd0, o_dbg_state} | 32'(m_rw) << 4, 32'h12);
        rst = 1; d_strobe = 0;
        tick();
        rst = 0;
        mid();
        check("rw_after_strobe", 32'(m_strobe), 32'd0);
        check("rw_after_ready", 32'(d_ready), 32'd0);
        check("rw_after_state", 32'(o_dbg_state), 32'd0);
        i_strobe = 1; d_strobe = 1;
        tick();
        mid();
        check("rw_tie_to_d", 32'(o_dbg_state), 32'd2);
        m_ready = 1;
        tick();
        m_ready = 0; i_strobe = 0; d_strobe = 0;

        // Stray m_ready while idle.
        mid();
        m_ready = 1; m_dout = 32'h0BAD_F00D;
        #1;
        check("idle_mr_ready", {30'd0, i_ready, d_ready}, 32'd0);
        check("idle_mr_din", d_din, 32'h0BAD_F00D);
        tick();
        mid();
        check("idle_mr_state", 32'(o_dbg_state), 32'd0);
        m_ready = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
